// File: rtl/mod241_pkg.sv
// rtl/mod241_pkg.sv - shared constants and FSM state type for the mod-241 serial reducer
package mod241_pkg;

  localparam int MOD241_WIDTH = 500;
  localparam int MOD241_CHUNK = 6;
  localparam int MOD241_MOD   = 241;
  localparam int MOD241_RES_W = 8;

  function automatic int nchunk(input int width, input int chunk);
    return (width + chunk - 1) / chunk;
  endfunction

  localparam int MOD241_NCHUNK = nchunk(MOD241_WIDTH, MOD241_CHUNK);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mod241_horner_step.sv
// rtl/mod241_horner_step.sv - one Horner step: (acc * 2^CHUNK + chunk) mod MOD, purely combinational
module mod241_horner_step
  import mod241_pkg::*;
#(
  parameter int CHUNK = MOD241_CHUNK,
  parameter int MOD   = MOD241_MOD
) (
  input  logic [MOD241_RES_W-1:0] i_acc,
  input  logic [CHUNK-1:0]        i_chunk,
  output logic [MOD241_RES_W-1:0] o_acc
);

  localparam int               SUM_W = MOD241_RES_W + CHUNK;
  localparam logic [SUM_W-1:0] MOD_W = SUM_W'(MOD);

  logic [SUM_W-1:0] w_sum;

  // Concatenation is acc*2^CHUNK + chunk at full width; acc < MOD keeps it exact.
  assign w_sum = {i_acc, i_chunk};
  assign o_acc = MOD241_RES_W'(w_sum % MOD_W);

endmodule

// File: rtl/mod241_serial_reducer.sv
// rtl/mod241_serial_reducer.sv - serial residue of a wide operand modulo 241, MSB chunk first
module mod241_serial_reducer
  import mod241_pkg::*;
#(
  parameter int WIDTH = MOD241_WIDTH,
  parameter int CHUNK = MOD241_CHUNK,
  parameter int MOD   = MOD241_MOD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_res,
  output logic             busy
);

  localparam int               NCHUNK  = nchunk(WIDTH, CHUNK);
  localparam int               PAD_W   = NCHUNK * CHUNK;
  localparam int               IDX_W   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NCHUNK - 1);

  state_e           r_state;
  logic [PAD_W-1:0] r_operand;
  logic [7:0]       r_acc;
  logic [IDX_W-1:0] r_idx;
  logic             r_in_ready;
  logic             r_busy;
  logic             r_out_valid;
  logic [7:0]       r_out_res;

  logic [CHUNK-1:0] w_chunk;
  logic [7:0]       w_acc_next;

  // Operand is held still; the chunk index walks down from the zero-padded top chunk.
  assign w_chunk = r_operand[r_idx*CHUNK +: CHUNK];

  mod241_horner_step #(
    .CHUNK(CHUNK),
    .MOD  (MOD)
  ) u_step (
    .i_acc  (r_acc),
    .i_chunk(w_chunk),
    .o_acc  (w_acc_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_acc       <= '0;
      r_idx       <= '0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_res   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_operand  <= PAD_W'(in_data);
            r_acc      <= '0;
            r_idx      <= IDX_TOP;
            r_state    <= ST_RUN;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        ST_RUN: begin
          r_acc <= w_acc_next;
          if (r_idx == '0) begin
            r_state     <= ST_DONE;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
            r_out_res   <= w_acc_next;
          end else begin
            r_idx <= r_idx - 1'b1;
          end
        end
        ST_DONE: begin
          // in_ready rises only after the consume edge, so no same-cycle re-accept.
          if (out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_out_res   <= '0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
          r_out_valid <= 1'b0;
          r_out_res   <= '0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign out_res   = r_out_res;

endmodule

// File: tb/tb_mod241_serial_reducer.sv
// tb/tb_mod241_serial_reducer.sv - self-checking bench for mod241_serial_reducer
module tb_mod241_serial_reducer;

  localparam int W   = 500;
  localparam int NCH = 84;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   out_res;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;
  int n_viol   = 0;

  typedef struct {
    string        name;
    logic [W-1:0] data;
    logic [7:0]   exp;
  } vec_t;

  vec_t vecs[7];

  mod241_serial_reducer #(
    .WIDTH(W),
    .CHUNK(6),
    .MOD  (241)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_res  (out_res),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (!out_valid && out_res != 8'd0) n_viol++;
      if (out_valid && out_res >= 8'd241) n_viol++;
      if (in_ready && busy) n_viol++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Bit-serial residue: r = (2r + bit) mod 241, MSB first.
  function automatic logic [7:0] ref_mod(input logic [W-1:0] v);
    int r = 0;
    for (int i = W - 1; i >= 0; i--) r = (r * 2 + int'(v[i])) % 241;
    return 8'(r);
  endfunction

  function automatic logic [W-1:0] rand_op();
    logic [511:0] t;
    logic [W-1:0] v;
    int mode = $urandom_range(0, 3);
    for (int i = 0; i < 16; i++) t[i*32 +: 32] = $urandom;
    v = t[W-1:0];
    case (mode)
      1: v = W'($urandom_range(0, 100000));
      2: begin v = '1; v[$urandom_range(0, W - 1)] = 1'b0; end
      3: begin v = '0; v[$urandom_range(0, W - 1)] = 1'b1; end
      default: ;
    endcase
    return v;
  endfunction

  task automatic apply(input logic [W-1:0] d);
    int n = 0;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      return;
    end
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) check("result_timeout", 32'd0, 32'd1);
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int           lat;
    int           n;
    logic [7:0]   first;
    logic [7:0]   res;
    logic [W-1:0] d;
    bit           seen;
    bit           done;

    vecs[0] = '{"zero",     '0,          8'd0};
    vecs[1] = '{"m241",     W'(241),     8'd0};
    vecs[2] = '{"m240",     W'(240),     8'd240};
    vecs[3] = '{"pow499",   '0,          8'd113};
    vecs[3].data[W-1] = 1'b1;
    vecs[4] = '{"all_ones", '1,          8'd225};
    vecs[5] = '{"v64",      W'(64),      8'd64};
    vecs[6] = '{"v15424",   W'(15424),   8'd0};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_in_ready",  32'(in_ready),  32'd1);
    check("reset_busy",      32'(busy),      32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_res",   32'(out_res),   32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      apply(vecs[i].data);
      check({vecs[i].name, "_busy"}, 32'(busy), 32'd1);
      wait_valid(lat);
      check({vecs[i].name, "_latency"}, 32'(lat), 32'(NCH));
      check({vecs[i].name, "_res"}, 32'(out_res), 32'(vecs[i].exp));
      check({vecs[i].name, "_in_ready_done"}, 32'(in_ready), 32'd0);
      take();
      check({vecs[i].name, "_valid_fall"}, 32'(out_valid), 32'd0);
      check({vecs[i].name, "_in_ready_back"}, 32'(in_ready), 32'd1);
    end

    d = rand_op();
    apply(d);
    wait_valid(lat);
    first = out_res;
    check("hold_res_model", 32'(first), 32'(ref_mod(d)));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_valid",    32'(out_valid), 32'd1);
      check("hold_res",      32'(out_res),   32'(first));
      check("hold_in_ready", 32'(in_ready),  32'd0);
    end
    take();

    apply(rand_op());
    repeat (40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_in_ready",  32'(in_ready),  32'd1);
    check("abort_busy",      32'(busy),      32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    seen = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_result", 32'(seen), 32'd0);
    apply(W'(480));
    wait_valid(lat);
    check("after_abort_480", 32'(out_res), 32'd239);
    take();

    apply(rand_op());
    wait_valid(lat);
    rst = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b0;
    check("rst_done_valid",    32'(out_valid), 32'd0);
    check("rst_done_in_ready", 32'(in_ready),  32'd1);
    check("rst_done_res",      32'(out_res),   32'd0);

    d = rand_op();
    apply(d);
    n = 0;
    while (!out_valid && n < 200) begin
      in_valid = ~in_valid;
      in_data  = rand_op();
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    check("ignore_inputs_res", 32'(out_res), 32'(ref_mod(d)));
    take();

    for (int k = 0; k < 1000; k++) begin
      d = rand_op();
      apply(d);
      n = 0;
      done = 1'b0;
      res = '0;
      while (!done && n < 400) begin
        if (out_valid) begin
          out_ready = ($urandom_range(0, 7) != 0);
          if (out_ready) begin
            res  = out_res;
            done = 1'b1;
          end
        end else begin
          out_ready = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        n++;
      end
      out_ready = 1'b0;
      if (!done) check("random_timeout", 32'd0, 32'd1);
      check("random_res",   32'(res), 32'(ref_mod(d)));
      check("random_range", 32'(res < 8'd241), 32'd1);
    end

    check("invariants", 32'(n_viol), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mod241_serial_reducer.md
MOD241_SERIAL_REDUCER -- requirements
Module: mod241_serial_reducer

Interface
REQ-001 SHALL have parameter WIDTH, default 500: operand width in bits.
REQ-002 SHALL have parameter CHUNK, default 6: bits consumed per step.
REQ-003 SHALL have parameter MOD, default 241: modulus; result width is 8 bits.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  operand offered.
REQ-007 SHALL have port in_ready  output  1  block can accept an operand.
REQ-008 SHALL have port in_data  input  WIDTH  operand, unsigned.
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  consumer takes result.
REQ-011 SHALL have port out_res  output  8  in_data mod MOD, range 0..240.
REQ-012 SHALL have port busy  output  1  high while state is RUN.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE.
REQ-014 SHALL drive in_ready = 1 only in IDLE, and busy = 1 only in RUN.
REQ-015 SHALL, on an edge with IDLE and in_valid = 1, capture in_data into an operand register, clear the accumulator to 0, set chunk index to NCHUNK-1, and enter RUN.
REQ-016 SHALL define NCHUNK = ceil(WIDTH/CHUNK) (84 at defaults); the top chunk is zero-extended (bits 499:498 plus four zeros).
REQ-017 SHALL, on each RUN edge, update acc <= (acc*64 + chunk[idx]) mod MOD and decrement idx, processing MSB chunk first (Horner).
REQ-018 SHALL keep acc < MOD after every step; intermediate acc*64+chunk SHALL be at least 14 bits wide, with no truncation.
REQ-019 SHALL leave RUN on the edge that processes idx = 0, enter DONE, and present acc on out_res with out_valid = 1 in the following cycle.
REQ-020 SHALL have a fixed latency of NCHUNK edges from the acceptance edge to the DONE entry edge (84 at defaults).
REQ-021 SHALL hold out_valid and out_res stable in DONE while out_ready = 0.
REQ-022 SHALL return to IDLE on the edge where out_valid = 1 and out_ready = 1; out_valid SHALL fall on that edge.
REQ-023 SHALL NOT accept an operand in the same cycle a result is consumed; the next acceptance is possible one cycle later.
REQ-024 SHALL ignore in_valid and in_data in RUN and DONE; the captured operand SHALL NOT change during RUN.
REQ-025 SHALL drive out_res = 0 whenever out_valid = 0.

Reset
REQ-026 SHALL, on any edge with rst = 1 in any state (including mid-RUN and mid-DONE), go to IDLE with acc = 0, idx = 0, out_valid = 0, busy = 0 and in_ready = 1 in the next cycle.
REQ-027 SHALL give rst priority over every handshake on the same edge; no result from an aborted operation is ever presented.

Structure
REQ-028 SHALL place MOD, CHUNK, WIDTH defaults, NCHUNK and the state enum typedef in shared package mod241_pkg.
REQ-029 SHALL isolate the per-step reduction in combinational sub-module mod241_horner_step (inputs acc[7:0] and chunk[5:0], output 8-bit next acc), so it can be swapped for an ABC-generated LUT netlist.
REQ-030 SHALL register all outputs, with no combinational path from in_* to out_*.

Verification
REQ-031 SHALL cover: in_data = 0 -> out_res = 0, with out_valid rising 85 cycles after the acceptance cycle.
REQ-032 SHALL cover: in_data = 241 -> 0; in_data = 240 -> 240; in_data = 2^499 -> 113; all-ones (2^500-1) -> 225.
REQ-033 SHALL cover: out_ready held low for 10 cycles in DONE -> out_valid = 1 and out_res unchanged throughout; in_ready = 0 throughout.
REQ-034 SHALL cover: rst asserted at RUN step 40 -> IDLE next cycle, out_valid never rises; a new operand of 480 then yields 239.
REQ-035 SHALL cover: in_valid toggled with changing in_data during RUN -> result equals residue of the originally captured operand.
REQ-036 SHALL cover: 1000 random operands back-to-back with random out_ready -> every out_res matches a reference model, and out_res < 241 always.
